sseg_mux_n: RTL and testbench

Parametrised multiplexed seven-segment display controller, the successor to the fixed 4-digit sseg + counter pair. It drives any number of digits and has a built-in refresh prescaler, hex decode, per-digit decimal point and blanking, and PWM brightness control. Display data is double-buffered so updates take effect only at frame boundaries, giving tear-free updates. It sits between the datapath, which supplies nibbles, and the board anode/cathode pins.

---
 rtl/sseg_mux_n.sv | 169 ++++++++++++++++
 tb/tb_sseg_mux_n.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sseg_mux_n.sv
// sseg_mux_n: multiplexed seven-segment display controller for DIGITS digits.
// A refresh prescaler walks the digit index. A free-running PWM counter dims
// the display. Digit data is double-buffered (pending -> active) and only
// swapped at frame boundaries, so updates never tear mid-scan.
module sseg_mux_n #(
  parameter int DIGITS     = 4,
  parameter int CLK_DIV    = 100000,
  parameter int BRIGHT_W   = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   digits,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic [BRIGHT_W-1:0]   brightness,
  input  logic                  load,
  output logic [DIGITS-1:0]     sseg_an,
  output logic [6:0]            sseg_ca,
  output logic                  sseg_dp,
  output logic                  frame_done
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  // XOR mask that converts active-high pin values to board polarity
  localparam logic            INV        = (ACTIVE_LOW != 0);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0]   IDX_LAST   = IW'(DIGITS - 1);

  // Hex nibble to active-high segment pattern, bit 0 = a .. bit 6 = g
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [BRIGHT_W-1:0]   pwm_q, pwm_d;
  logic [4*DIGITS-1:0]   pend_dig_q, pend_dig_d, act_dig_q, act_dig_d;
  logic [DIGITS-1:0]     pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [DIGITS-1:0]     pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [6:0]            ca_q, ca_d;
  logic                  dpo_q, dpo_d;
  logic                  fd_q, fd_d;
  logic                  tick_s, boundary_s, on_s;
  logic [3:0]            nib_s;
  logic [DIGITS-1:0]     an_lit_s;

  // Scan timing: prescaler, digit index and PWM counter
  always_comb begin
    tick_s     = (presc_q == PRESC_LAST);
    boundary_s = tick_s && (idx_q == IDX_LAST);
    pwm_d      = pwm_q + BRIGHT_W'(1);
    fd_d       = boundary_s;
    if (tick_s) begin
      presc_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else begin
      presc_d = presc_q + PW'(1);
      idx_d   = idx_q;
    end
  end

  // Double buffer: load fills pending; the frame boundary promotes it,
  // taking the live inputs directly when load lands on the boundary
  always_comb begin
    if (load) begin
      pend_dig_d   = digits;
      pend_dp_d    = dp;
      pend_blank_d = blank;
    end else begin
      pend_dig_d   = pend_dig_q;
      pend_dp_d    = pend_dp_q;
      pend_blank_d = pend_blank_q;
    end
    if (boundary_s && load) begin
      act_dig_d   = digits;
      act_dp_d    = dp;
      act_blank_d = blank;
    end else if (boundary_s) begin
      act_dig_d   = pend_dig_q;
      act_dp_d    = pend_dp_q;
      act_blank_d = pend_blank_q;
    end else begin
      act_dig_d   = act_dig_q;
      act_dp_d    = act_dp_q;
      act_blank_d = act_blank_q;
    end
  end

  // Output stage: cathodes follow the index, and only the anode gates visibility
  always_comb begin
    nib_s    = act_dig_q[{idx_q, 2'b00} +: 4];
    on_s     = (brightness == {BRIGHT_W{1'b1}}) || (pwm_q < brightness);
    an_lit_s = '0;
    if (on_s && !act_blank_q[idx_q]) begin
      an_lit_s[idx_q] = 1'b1;
    end else begin
      an_lit_s = '0;
    end
    an_d  = an_lit_s ^ {DIGITS{INV}};
    ca_d  = seg_decode(nib_s) ^ {7{INV}};
    dpo_d = act_dp_q[idx_q] ^ INV;
  end

  // State and registered outputs; reset leaves all pins at their inactive level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pwm_q        <= '0;
      pend_dig_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      act_dig_q    <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '0;
      an_q         <= {DIGITS{INV}};
      ca_q         <= {7{INV}};
      dpo_q        <= INV;
      fd_q         <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pwm_q        <= pwm_d;
      pend_dig_q   <= pend_dig_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      act_dig_q    <= act_dig_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      an_q         <= an_d;
      ca_q         <= ca_d;
      dpo_q        <= dpo_d;
      fd_q         <= fd_d;
    end
  end

  assign sseg_an    = an_q;
  assign sseg_ca    = ca_q;
  assign sseg_dp    = dpo_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_sseg_mux_n.sv
// Self-checking bench for sseg_mux_n (4 digits, 4 clocks per slot, active-low).
// The reference model derives every output from the number of clock edges
// since reset plus a pending/active buffer pair.
module tb_sseg_mux_n;
  localparam int ND = 4;
  localparam int CD = 4;
  localparam int FRAME = ND * CD;

  logic        clk;
  logic        rst;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic [3:0]  brightness;
  logic        load;
  logic [3:0]  sseg_an;
  logic [6:0]  sseg_ca;
  logic        sseg_dp;
  logic        frame_done;

  sseg_mux_n #(.DIGITS(ND), .CLK_DIV(CD), .BRIGHT_W(4), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .digits(digits), .dp(dp), .blank(blank),
    .brightness(brightness), .load(load), .sseg_an(sseg_an),
    .sseg_ca(sseg_ca), .sseg_dp(sseg_dp), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active-high segment table, g..a
  logic [6:0] dec [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int n_chk = 0;
  int n_pass = 0;
  logic chk_en = 1'b0;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: t = edges since reset release
  int          t;
  logic [15:0] pend_dig, act_dig;
  logic [3:0]  pend_dp, act_dp, pend_bl, act_bl;
  logic [3:0]  exp_an;
  logic [6:0]  exp_ca;
  logic        exp_dp, exp_fd;

  always @(posedge clk or posedge rst) begin
    int   slot_idx;
    int   pwm;
    logic lit;
    logic bnd;
    if (rst) begin
      t <= 0;
      pend_dig <= '0; pend_dp <= '0; pend_bl <= '0;
      act_dig <= '0;  act_dp <= '0;  act_bl <= '0;
      exp_an <= 4'hF; exp_ca <= 7'h7F; exp_dp <= 1'b1; exp_fd <= 1'b0;
    end else begin
      slot_idx = (t / CD) % ND;
      pwm      = t % 16;
      lit      = (brightness == 4'd15) || (pwm < int'(brightness));
      bnd      = (t % FRAME) == FRAME - 1;
      exp_an   <= (lit && !act_bl[slot_idx]) ? ~(4'd1 << slot_idx) : 4'hF;
      exp_ca   <= ~dec[act_dig[slot_idx*4 +: 4]];
      exp_dp   <= ~act_dp[slot_idx];
      exp_fd   <= bnd;
      if (bnd) begin
        act_dig <= load ? digits : pend_dig;
        act_dp  <= load ? dp : pend_dp;
        act_bl  <= load ? blank : pend_bl;
      end
      if (load) begin
        pend_dig <= digits; pend_dp <= dp; pend_bl <= blank;
      end
      t <= t + 1;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("an", 16'(sseg_an), 16'(exp_an));
      check("ca", 16'(sseg_ca), 16'(exp_ca));
      check("dp", 16'(sseg_dp), 16'(exp_dp));
      check("frame_done", 16'(frame_done), 16'(exp_fd));
      check("one_anode", 16'($countones(~sseg_an) <= 1), 16'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  task automatic goto_edge(input int k);
    while (t < k) @(negedge clk);
  endtask

  int cnt;

  initial begin
    rst = 1'b1; digits = '0; dp = '0; blank = '0; brightness = 4'd15; load = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_an", 16'(sseg_an), 16'h000F);
    check("rst_ca", 16'(sseg_ca), 16'h007F);
    check("rst_dp", 16'(sseg_dp), 16'h0001);
    check("rst_fd", 16'(frame_done), 16'h0000);
    chk_en = 1'b1;
    rst = 1'b0;

    // Idle scan rotation and frame pulse
    goto_edge(1);  check("scan_d0", 16'(sseg_an), 16'h000E);
                   check("scan_ca0", 16'(sseg_ca), 16'h0040);
    goto_edge(5);  check("scan_d1", 16'(sseg_an), 16'h000D);
    goto_edge(9);  check("scan_d2", 16'(sseg_an), 16'h000B);
    goto_edge(13); check("scan_d3", 16'(sseg_an), 16'h0007);
    goto_edge(15); check("fd_early", 16'(frame_done), 16'h0000);
    goto_edge(16); check("fd_pulse", 16'(frame_done), 16'h0001);
    goto_edge(17); check("fd_once", 16'(frame_done), 16'h0000);
                   check("scan_wrap", 16'(sseg_an), 16'h000E);

    // Mid-frame load: old data holds until the boundary
    digits = 16'hA3F0; dp = 4'b0100; load = 1'b1;
    goto_edge(18); load = 1'b0; digits = 16'hFFFF; dp = 4'hF;
    check("hold_d0", 16'(sseg_ca), 16'h0040);
    goto_edge(29); check("hold_d3", 16'(sseg_ca), 16'h0040);
    goto_edge(33); check("new_d0", 16'(sseg_ca), 16'h0040);
    goto_edge(37); check("new_d1", 16'(sseg_ca), 16'h000E);
                   check("new_dp1", 16'(sseg_dp), 16'h0001);
    goto_edge(41); check("new_d2", 16'(sseg_ca), 16'h0030);
                   check("new_dp2", 16'(sseg_dp), 16'h0000);
    goto_edge(45); check("new_d3", 16'(sseg_ca), 16'h0008);

    // Load in the exact boundary cycle uses the bypass path
    goto_edge(63); digits = 16'h1234; dp = 4'b0000; load = 1'b1;
    goto_edge(64); load = 1'b0;
    goto_edge(65); check("byp_d0", 16'(sseg_ca), 16'h0019);
    goto_edge(77); check("byp_d3", 16'(sseg_ca), 16'h0079);

    // Brightness: off, quarter duty, full
    goto_edge(68); brightness = 4'd0;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin @(negedge clk); if (sseg_an != 4'hF) cnt++; end
    check("bright0", 16'(cnt), 16'd0);
    brightness = 4'd4; @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 64; i++) begin @(negedge clk); if (sseg_an != 4'hF) cnt++; end
    check("bright4", 16'(cnt), 16'd16);
    brightness = 4'd15; @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 64; i++) begin @(negedge clk); if (sseg_an != 4'hF) cnt++; end
    check("bright15", 16'(cnt), 16'd64);

    // Blank digit 1
    goto_edge(239); blank = 4'b0010; load = 1'b1;
    goto_edge(240); load = 1'b0; blank = 4'b0000;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin @(negedge clk); if (sseg_an[1] == 1'b0) cnt++; end
    check("blank_an1", 16'(cnt), 16'd0);
    goto_edge(278); check("blank_slot_an", 16'(sseg_an), 16'h000F);
                    check("blank_slot_ca", 16'(sseg_ca), 16'h0030);
    goto_edge(282); check("blank_d2_lit", 16'(sseg_an), 16'h000B);

    // Randomized traffic
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      digits = 16'($urandom);
      dp     = 4'($urandom);
      blank  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      load   = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 31) == 0) brightness = 4'($urandom);
    end

    // Reset in the digit-2 slot
    @(negedge clk); load = 1'b0; brightness = 4'd15;
    while ((((t - 1) / CD) % ND) != 2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_an", 16'(sseg_an), 16'h000F);
    check("mid_rst_ca", 16'(sseg_ca), 16'h007F);
    check("mid_rst_dp", 16'(sseg_dp), 16'h0001);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    goto_edge(1);
    check("restart_an", 16'(sseg_an), 16'h000E);
    check("restart_ca", 16'(sseg_ca), 16'h0040);
    cnt = 0;
    for (int i = 0; i < 14; i++) begin @(negedge clk); if (frame_done) cnt++; end
    check("restart_no_fd", 16'(cnt), 16'd0);
    goto_edge(16); check("restart_fd", 16'(frame_done), 16'h0001);
    @(negedge clk);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
